// File: rtl/ahb_rom_rd_master.sv
// ahb_rom_rd_master: AHB-Lite initiator that reads a block of words from ROM into a valid/ready stream.
// Define AHB_RDM_INCR_BURST_EN for INCR bursts with SEQ beats; by default every beat is a SINGLE NONSEQ.
module ahb_rom_rd_master #(
    parameter int p_LW = 8,
    parameter int p_FD = 2
) (
    input  logic            hclk,
    input  logic            hresetn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [31:0]     cmd_addr,
    input  logic [p_LW-1:0] cmd_len,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [31:0]     rd_data,
    output logic            done,
    output logic            err,
    output logic [31:0]     haddr,
    output logic [1:0]      htrans,
    output logic [2:0]      hburst,
    output logic [2:0]      hsize,
    output logic            hwrite,
    output logic [3:0]      hprot,
    output logic            hmastlock,
    output logic [31:0]     hwdata,
    input  logic            hready,
    input  logic [1:0]      hresp,
    input  logic [31:0]     hrdata
);
    localparam int PW = (p_FD > 1) ? $clog2(p_FD) : 1;
    localparam int CW = $clog2(p_FD + 1);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [2:0] BU_SINGLE = 3'b000;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ERR} state_t;

    state_t          state, state_nxt;
    logic [p_LW-1:0] remain;
    logic            pend;
    logic            hold;
    logic [CW-1:0]   fifo_count;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [31:0]     mem [p_FD];

    logic accept, issue, addr_acc, err_det, push, pop, credit, fin;
    logic unused_bits;

    assign accept    = cmd_valid && (state == S_IDLE);
    assign cmd_ready = (state == S_IDLE);
    assign rd_valid  = (fifo_count != '0);
    assign pop       = rd_valid && rd_ready;
    // A word popped this cycle frees its slot in time for a beat issued now.
    assign credit    = (int'(fifo_count) + int'(pend) - int'(pop)) < p_FD;
    assign issue     = (state == S_RUN) && (hold || credit);
    assign addr_acc  = issue && hready;
    assign err_det   = ((state == S_RUN) || (state == S_DRAIN)) && pend && hresp[0] && !hready;
    assign push      = pend && hready && !hresp[0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        fin       = 1'b0;
        unique case (state)
            S_IDLE:  if (accept && cmd_len != '0) state_nxt = S_RUN;
            S_RUN: begin
                if (err_det)                                state_nxt = S_ERR;
                else if (addr_acc && remain == p_LW'(1))    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (err_det) state_nxt = S_ERR;
                else if (push) begin
                    state_nxt = S_IDLE;
                    fin       = 1'b1;
                end
            end
            S_ERR: begin
                state_nxt = S_IDLE;
                fin       = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state  <= S_IDLE;
            haddr  <= '0;
            remain <= '0;
            pend   <= 1'b0;
            hold   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= fin || (accept && cmd_len == '0);
            hold  <= issue && !hready && !err_det;
            if (accept) begin
                haddr  <= {cmd_addr[31:2], 2'b00};
                remain <= cmd_len;
                err    <= 1'b0;
            end else begin
                if (addr_acc) begin
                    haddr  <= haddr + 32'd4;
                    remain <= remain - p_LW'(1);
                end
                if (err_det) err <= 1'b1;
            end
            // The beat in its data phase when ERROR arrives is dropped, never pushed.
            if (err_det || state == S_ERR) pend <= 1'b0;
            else if (hready)               pend <= addr_acc;
        end
    end

`ifdef AHB_RDM_INCR_BURST_EN
    logic seq_ok;

    // A beat may be SEQ only if the previous beat was accepted with no IDLE cycle in between.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) seq_ok <= 1'b0;
        else          seq_ok <= issue ? (hready || seq_ok) : 1'b0;
    end

    assign htrans = !issue ? TR_IDLE : (seq_ok && haddr[9:0] != '0) ? 2'b11 : TR_NONSEQ;
    assign hburst = issue ? 3'b001 : BU_SINGLE;
`else
    assign htrans = issue ? TR_NONSEQ : TR_IDLE;
    assign hburst = BU_SINGLE;
`endif

    assign hsize     = 3'b010;
    assign hwrite    = 1'b0;
    assign hprot     = 4'b0011;
    assign hmastlock = 1'b0;
    assign hwdata    = '0;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(p_FD - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: the storage array has no reset; rd_data is gated by rd_valid so stale words never escape.
    always_ff @(posedge hclk) begin
        if (push) mem[wr_ptr] <= hrdata;
    end

    assign rd_data     = rd_valid ? mem[rd_ptr] : '0;
    assign unused_bits = ^{hresp[1], cmd_addr[1:0]};

endmodule

// File: tb/tb_ahb_rom_rd_master.sv
// tb_ahb_rom_rd_master: randomized bench with an AHB ROM slave model and a word-stream scoreboard.
// Expectations come from (start, len, error beat) per command, independent of the DUT's internals.
`timescale 1ns/1ps
module tb_ahb_rom_rd_master;
    localparam int LW = 8;
    localparam int FD = 2;

    logic            hclk = 1'b0;
    logic            hresetn = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [31:0]     cmd_addr = '0;
    logic [LW-1:0]   cmd_len = '0;
    logic            rd_valid;
    logic            rd_ready;
    logic [31:0]     rd_data;
    logic            done, err;
    logic [31:0]     haddr, hwdata, hrdata;
    logic [1:0]      htrans, hresp;
    logic [2:0]      hburst, hsize;
    logic            hwrite, hmastlock, hready;
    logic [3:0]      hprot;

    always #5 hclk = ~hclk;

    ahb_rom_rd_master #(.p_LW(LW), .p_FD(FD)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .err(err),
        .haddr(haddr), .htrans(htrans), .hburst(hburst), .hsize(hsize), .hwrite(hwrite),
        .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Per-command reference state.
    logic [31:0] cmd_start = '0;
    int          cmd_n = 0;
    int          err_beat = 0, wait_beat = 0, wait_n = 0, rand_wait = 0;
    int          beats = 0;
    int          max_beats = 0;
    int          acc_cycle[$];
    logic [1:0]  acc_trans[$];
    logic [31:0] acc_addr_q[$];
    logic [31:0] exp_q[$];
    int          done_cnt = 0, done_base = 0;
    logic        err_at_done = 1'b0;
    int          rd_mode = 1;
    int          cyc = 0;
    int          hold_checks = 0, err_idle_checks = 0;
    int          acc_cmd_cyc = 0, first_pop_cyc = 0;
    logic [31:0] first_word = '0;
    bit          first_pop_pending = 0;
    bit          gap = 1;

    always @(posedge hclk) cyc <= cyc + 1;

    // AHB ROM slave plus address-phase protocol checks.
    initial begin
        logic        acc_n;
        logic [31:0] acc_a;
        logic        dp_valid;
        logic [31:0] dp_addr;
        int          dp_beat, dp_wait, dp_errc;
        logic [1:0]  prev_trans;
        logic [31:0] prev_addr;
        logic        prev_hready, prev_err;
        logic [1:0]  exp_tr;
        logic [2:0]  exp_bu;
        hready = 1'b1; hresp = 2'b00; hrdata = '0;
        dp_valid = 0; dp_addr = '0; dp_beat = 0; dp_wait = 0; dp_errc = 0;
        prev_trans = 2'b00; prev_addr = '0; prev_hready = 1'b1; prev_err = 1'b0;
        forever begin
            @(negedge hclk);
            acc_n = hresetn && hready && htrans[1];
            acc_a = haddr;
            if (hresetn) begin
                if (!prev_hready && prev_trans[1] && !prev_err) begin
                    hold_checks++;
                    check("htrans_hold", htrans, prev_trans);
                    check("haddr_hold", haddr, prev_addr);
                end
                if (prev_err && !prev_hready) begin
                    err_idle_checks++;
                    check("htrans_idle_after_error", htrans, 2'b00);
                end
                if (acc_n) begin
`ifdef AHB_RDM_INCR_BURST_EN
                    exp_tr = (gap || haddr[9:0] == 10'd0) ? 2'b10 : 2'b11;
                    exp_bu = 3'b001;
`else
                    exp_tr = 2'b10;
                    exp_bu = 3'b000;
`endif
                    check("beat_within_command", 32'(beats < max_beats), 32'd1);
                    check("haddr_seq", haddr, cmd_start + 32'(4 * beats));
                    check("htrans_type", htrans, exp_tr);
                    check("hburst", hburst, exp_bu);
                    acc_cycle.push_back(cyc);
                    acc_trans.push_back(htrans);
                    acc_addr_q.push_back(haddr);
                    beats++;
                    gap = 0;
                end else if (!htrans[1]) begin
                    gap = 1;
                end
            end
            prev_trans = htrans; prev_addr = haddr; prev_hready = hready; prev_err = hresp[0];
            @(posedge hclk);
            #1;
            if (!hresetn) begin
                dp_valid = 0; hready = 1'b1; hresp = 2'b00;
            end else begin
                if (hready) begin
                    dp_valid = acc_n; dp_addr = acc_a; dp_beat = beats; dp_errc = 0;
                    if (dp_beat == wait_beat) dp_wait = wait_n;
                    else if (rand_wait > 0 && $urandom_range(99) < rand_wait) dp_wait = $urandom_range(1, 3);
                    else dp_wait = 0;
                end
                if (!dp_valid) begin
                    hready = 1'b1; hresp = 2'b00; hrdata = $urandom;
                end else if (dp_beat == err_beat) begin
                    hresp = 2'b01; hready = (dp_errc == 1); hrdata = $urandom; dp_errc++;
                end else if (dp_wait > 0) begin
                    hready = 1'b0; hresp = 2'b00; hrdata = $urandom; dp_wait--;
                end else begin
                    hready = 1'b1; hresp = 2'b00; hrdata = rom(dp_addr);
                end
            end
        end
    end

    // Read-stream scoreboard: every popped word must be the next expected ROM word.
    initial begin
        forever begin
            @(negedge hclk);
            if (hresetn && rd_valid && rd_ready) begin
                if (first_pop_pending) begin
                    first_pop_cyc = cyc; first_word = rd_data; first_pop_pending = 0;
                end
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_unexpected_word: got %h expected no word", rd_data);
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge hclk);
            if (hresetn && done) begin
                done_cnt++;
                err_at_done = err;
            end
        end
    end

    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge hclk);
            #1;
            rd_ready = (rd_mode == 2) ? ($urandom_range(1) == 1) : (rd_mode == 1);
        end
    end

    task automatic start_cmd(input logic [31:0] a, input int n, input int eb);
        int t = 0;
        @(negedge hclk);
        while (!cmd_ready && t < 500) begin
            @(negedge hclk);
            t++;
        end
        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_start = {a[31:2], 2'b00};
        cmd_n = n; err_beat = eb; beats = 0;
        max_beats = (eb > 0) ? eb : n;
        acc_cycle.delete(); acc_trans.delete(); acc_addr_q.delete();
        for (int k = 0; k < ((eb > 0) ? eb - 1 : n); k++) exp_q.push_back(rom(cmd_start + 32'(4 * k)));
        done_base = done_cnt;
        first_pop_pending = 1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = LW'(n);
        @(posedge hclk);
        #1;
        acc_cmd_cyc = cyc;
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = LW'($urandom);
    endtask

    task automatic finish_cmd(input logic exp_err);
        int t = 0;
        int saved = rd_mode;
        while (done_cnt == done_base && t < 3000) begin
            @(negedge hclk);
            t++;
        end
        rd_mode = 1;
        t = 0;
        while ((exp_q.size() != 0 || rd_valid) && t < 200) begin
            @(negedge hclk);
            t++;
        end
        repeat (3) @(negedge hclk);
        check("done_count", 32'(done_cnt - done_base), 32'd1);
        check("err_at_done", err_at_done, exp_err);
        check("beat_count", 32'(beats), 32'(max_beats));
        check("words_left", 32'(exp_q.size()), 32'd0);
        rd_mode = saved;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int n, eb, h0, e0;

        repeat (3) @(negedge hclk);
        check("rst_htrans", htrans, 2'b00);
        check("rst_haddr", haddr, 32'h0);
        check("rst_hburst", hburst, 3'b000);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("hsize", hsize, 3'b010);
        check("hwrite", hwrite, 1'b0);
        check("hprot", hprot, 4'b0011);
        check("hmastlock", hmastlock, 1'b0);
        check("hwdata", hwdata, 32'h0);
        hresetn = 1'b1;
        rd_mode = 1;
        repeat (2) @(negedge hclk);

        // Zero-wait block read with an always-ready consumer.
        start_cmd(32'h100, 4, 0);
        finish_cmd(1'b0);
        check("t1_beats_recorded", 32'(acc_cycle.size()), 32'd4);
        check("t1_first_nonseq_latency", 32'(acc_cycle[0] - acc_cmd_cyc), 32'd0);
        check("t1_back_to_back", 32'(acc_cycle[3] - acc_cycle[0]), 32'd3);
        check("t1_addr0", acc_addr_q[0], 32'h100);
        check("t1_addr3", acc_addr_q[3], 32'h10C);
        check("t1_first_word_latency", 32'(first_pop_cyc - acc_cmd_cyc), 32'd2);
        check("t1_first_word", first_word, 32'hDEAD_0100);

        // Zero-length command: done only, no bus traffic.
        start_cmd(32'h200, 0, 0);
        @(negedge hclk);
        check("t2_done_pulse", done, 1'b1);
        check("t2_htrans_idle", htrans, 2'b00);
        check("t2_rd_valid", rd_valid, 1'b0);
        @(negedge hclk);
        check("t2_done_one_cycle", done, 1'b0);
        finish_cmd(1'b0);

        // Consumer stalled: only FD words may be in flight, busy commands ignored.
        rd_mode = 0;
        start_cmd(32'h1000, 6, 0);
        repeat (10) @(negedge hclk);
        check("t3_beats_capped", 32'(beats), 32'(FD));
        check("t3_htrans_idle", htrans, 2'b00);
        check("t3_rd_valid", rd_valid, 1'b1);
        check("t3_cmd_ready_busy", cmd_ready, 1'b0);
        cmd_valid = 1'b1; cmd_addr = 32'h5550; cmd_len = LW'(3);
        @(posedge hclk);
        #1;
        cmd_valid = 1'b0;
        rd_mode = 1;
        finish_cmd(1'b0);

        // Two wait states on beat 2.
        h0 = hold_checks;
        wait_beat = 2; wait_n = 2;
        start_cmd(32'h2000, 5, 0);
        finish_cmd(1'b0);
        wait_beat = 0;
        check("t4_hold_observed", 32'(hold_checks - h0 >= 2), 32'd1);

        // ERROR response on beat 3 of 5.
        e0 = err_idle_checks;
        start_cmd(32'h3000, 5, 3);
        finish_cmd(1'b1);
        check("t5_err_sticky", err, 1'b1);
        check("t5_idle_after_error_seen", 32'(err_idle_checks - e0), 32'd1);
        start_cmd(32'h40, 1, 0);
        @(negedge hclk);
        check("t5_err_cleared", err, 1'b0);
        finish_cmd(1'b0);

        // Crossing a 1KB boundary.
        start_cmd(32'h3F8, 4, 0);
        finish_cmd(1'b0);
        check("t6_addr2", acc_addr_q[2], 32'h400);
`ifdef AHB_RDM_INCR_BURST_EN
        check("t6_trans0", acc_trans[0], 2'b10);
        check("t6_trans1", acc_trans[1], 2'b11);
        check("t6_trans2", acc_trans[2], 2'b10);
        check("t6_trans3", acc_trans[3], 2'b11);
`else
        check("t6_trans1", acc_trans[1], 2'b10);
        check("t6_trans3", acc_trans[3], 2'b10);
`endif

        // Randomized commands, consumer back-pressure, wait states and errors.
        rd_mode = 2;
        rand_wait = 30;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(2))
                0:       a = $urandom;
                1:       a = 32'h3E0 + 32'($urandom_range(0, 15)) * 4 + 32'h400 * 32'($urandom_range(0, 3));
                default: a = 32'hFFFF_FFE0 + 32'($urandom_range(0, 7)) * 4;
            endcase
            n = (i == 20) ? 255 : $urandom_range(0, 12);
            eb = (n > 0 && $urandom_range(3) == 0) ? $urandom_range(1, n) : 0;
            start_cmd(a, n, eb);
            finish_cmd(eb > 0);
        end
        rand_wait = 0;

        // Reset in the middle of a command abandons it without a done pulse.
        rd_mode = 0;
        start_cmd(32'h500, 8, 0);
        repeat (6) @(negedge hclk);
        hresetn = 1'b0;
        exp_q.delete();
        @(negedge hclk);
        check("mr_htrans", htrans, 2'b00);
        check("mr_rd_valid", rd_valid, 1'b0);
        check("mr_cmd_ready", cmd_ready, 1'b1);
        check("mr_haddr", haddr, 32'h0);
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        repeat (5) @(negedge hclk);
        check("mr_no_done", 32'(done_cnt - done_base), 32'd0);
        rd_mode = 1;
        start_cmd(32'h600, 2, 0);
        finish_cmd(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
